// File: rtl/proc_stack_unit.sv
// LIFO stack with occupancy count, replace-top on simultaneous push/pop,
// and sticky overflow/underflow flags. Outputs derive only from registered state.
module proc_stack_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] top,
  output logic [PTR_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = PTR_W - 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PTR_W-1:0] CNT_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(DEPTH);

  logic [DATA_W-1:0] entry [DEPTH];
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              do_push;
  logic              do_pop;
  logic              do_replace;
  logic              ovf_evt;
  logic              unf_evt;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // Low bits of count wrap to 0 when full, so subtracting one still lands on DEPTH-1.
  assign top_idx = count[IDX_W-1:0] - IDX_ONE;
  assign top     = empty ? '0 : entry[top_idx];

  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    wr_idx     = count[IDX_W-1:0];
    if (push && pop) begin
      if (empty) begin
        do_push = 1'b1;
      end else begin
        do_replace = 1'b1;
        wr_idx     = top_idx;
      end
    end else if (push) begin
      if (full) begin
        ovf_evt = 1'b1;
      end else begin
        do_push = 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        unf_evt = 1'b1;
      end else begin
        do_pop = 1'b1;
      end
    end
  end

  // The array is not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && (do_push || do_replace)) begin
      entry[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CNT_ONE;
    end else if (do_pop) begin
      count <= count - CNT_ONE;
    end
  end

  // A new error in the same cycle as clr_err wins and keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow  & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
    end
  end

endmodule

// File: doc/proc_stack_unit.md
PROC_STACK_UNIT -- requirements
Module: proc_stack_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each stack entry.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; legal values are a power of two, 2..256.
REQ-003 SHALL have derived parameter PTR_W = log2(DEPTH)+1, width of the occupancy count.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port push, input, 1, write din onto the stack this cycle.
REQ-007 SHALL have port pop, input, 1, remove the top entry this cycle.
REQ-008 SHALL have port din, input, DATA_W, data to push.
REQ-009 SHALL have port clr_err, input, 1, clears the sticky error flags.
REQ-010 SHALL have port top, output, DATA_W, current top entry; 0 when empty.
REQ-011 SHALL have port count, output, PTR_W, number of valid entries (0..DEPTH).
REQ-012 SHALL have port empty, output, 1, high when count==0.
REQ-013 SHALL have port full, output, 1, high when count==DEPTH.
REQ-014 SHALL have port overflow, output, 1, sticky flag for a push dropped because the stack was full.
REQ-015 SHALL have port underflow, output, 1, sticky flag for a pop ignored because the stack was empty.

Function
REQ-016 SHALL store entries in a DEPTH x DATA_W register array indexed by a stack pointer sp equal to count.
REQ-017 SHALL, on push only with !full, write din to entry[sp] and increment count by 1; the new top is visible the next cycle.
REQ-018 SHALL, on pop only with !empty, decrement count by 1 and leave array contents unchanged.
REQ-019 SHALL, on push&pop with !empty, overwrite entry[sp-1] with din and leave count unchanged (replace-top), including when full.
REQ-020 SHALL, on push&pop with empty, act as push only, with no underflow.
REQ-021 SHALL, on push only with full, leave the array and count unchanged and set overflow.
REQ-022 SHALL, on pop only with empty, leave count at 0 and set underflow.
REQ-023 SHALL derive top, empty and full combinationally from registered state, with no input-to-output path.
REQ-024 SHALL have count change by at most 1 per cycle and never exceed DEPTH or wrap below 0.
REQ-025 SHALL, on clr_err, clear overflow and underflow next cycle; a same-cycle new error SHALL take priority, leaving the flag set.
REQ-026 SHALL hold all state when neither push nor pop is asserted.

Reset
REQ-027 SHALL, when reset=1 at a clock edge, set count=0, overflow=0 and underflow=0, regardless of push, pop or clr_err.
REQ-028 SHALL not require the array to be cleared by reset; top SHALL read 0 while empty.
REQ-029 SHALL, when reset is asserted mid-sequence, discard all entries; the first push after reset SHALL land at entry[0].

Verification
REQ-030 SHALL cover LIFO order: DEPTH=4; push 0x11,0x22,0x33 -> top=0x33, count=3; pop x3 -> top reads 0x22, then 0x11, then 0, and empty=1.
REQ-031 SHALL cover full and overflow: DEPTH=4; push 4 values then push 0xAA -> full=1, count=4, overflow=1, top unchanged; clr_err -> overflow=0 next cycle.
REQ-032 SHALL cover underflow: from reset, pop -> underflow=1, count=0; clr_err together with a second pop -> underflow stays 1.
REQ-033 SHALL cover replace-top: push 0x5, then push&pop with din=0x9 -> count=1, top=0x9; push&pop when empty with din=0x7 -> count=1, top=0x7.
REQ-034 SHALL cover reset mid-operation: push 3 entries, assert reset with push=1 -> count=0, empty=1, flags 0; push 0xC -> top=0xC, count=1.
REQ-035 SHALL cover a randomized push/pop/clr_err sequence against a reference model, with DATA_W=8, DEPTH=8 and DATA_W=32, DEPTH=16; count, top, full, empty and the flags SHALL match every cycle.
